// File: rtl/ram_window_reader.sv
// Reads a WIN x WIN window out of the single-port image RAM in raster order
// and streams the pixels over valid/ready through a 2-entry skid FIFO.
module ram_window_reader #(
  parameter int DEPTH_X      = 300,
  parameter int DEPTH_Y      = 300,
  parameter int ADDR_WIDTH_X = $clog2(DEPTH_X),
  parameter int ADDR_WIDTH_Y = $clog2(DEPTH_Y),
  parameter int DATA_WIDTH   = 8,
  parameter int WIN          = 20
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [ADDR_WIDTH_X-1:0]              org_x,
  input  logic [ADDR_WIDTH_Y-1:0]              org_y,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err,
  output logic [ADDR_WIDTH_X+ADDR_WIDTH_Y-1:0] ram_addr,
  output logic                                 ram_cs,
  output logic                                 ram_we,
  input  logic [DATA_WIDTH-1:0]                ram_rdData,
  output logic [DATA_WIDTH-1:0]                pix_data,
  output logic                                 pix_valid,
  input  logic                                 pix_ready,
  output logic                                 pix_last
);

  localparam int NPIX = WIN * WIN;
  localparam int CW   = $clog2(NPIX + 1);
  localparam logic [ADDR_WIDTH_X:0] WIN_X = (ADDR_WIDTH_X+1)'(WIN);
  localparam logic [ADDR_WIDTH_Y:0] WIN_Y = (ADDR_WIDTH_Y+1)'(WIN);
  localparam logic [ADDR_WIDTH_X:0] LIM_X = (ADDR_WIDTH_X+1)'(DEPTH_X);
  localparam logic [ADDR_WIDTH_Y:0] LIM_Y = (ADDR_WIDTH_Y+1)'(DEPTH_Y);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH_X-1:0] base_x, col;
  logic [ADDR_WIDTH_Y-1:0] base_y, row;
  logic [CW-1:0]           issue_cnt, out_cnt;
  logic                    inflight;
  logic [DATA_WIDTH-1:0]   buf_mem [2];
  logic                    rd_ptr, wr_ptr;
  logic [1:0]              occ, occ_next;
  logic [2:0]              level;
  logic                    push, pop, in_bounds;

  // Stream handshake: a pixel moves when pix_valid & pix_ready at a rising
  // edge; pix_valid/pix_data come straight from the FIFO head, so they hold
  // until accepted.
  assign push      = inflight;
  assign pix_valid = (occ != 2'd0);
  assign pop       = pix_valid & pix_ready;
  assign pix_data  = buf_mem[rd_ptr];
  assign pix_last  = pix_valid && (out_cnt == CW'(NPIX - 1));
  assign occ_next  = occ + {1'b0, push} - {1'b0, pop};

  // Issue only when the returning word is guaranteed a free FIFO slot.
  assign level    = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign ram_cs   = (state == READ) && (level < 3'd2);
  assign ram_we   = 1'b0;
  assign ram_addr = {base_y + row, base_x + col};

  assign in_bounds = (({1'b0, org_x} + WIN_X) <= LIM_X) &&
                     (({1'b0, org_y} + WIN_Y) <= LIM_Y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      base_x     <= '0;
      base_y     <= '0;
      col        <= '0;
      row        <= '0;
      issue_cnt  <= '0;
      out_cnt    <= '0;
      inflight   <= 1'b0;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      occ        <= 2'd0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      inflight <= ram_cs;
      occ      <= occ_next;
      if (push) begin
        buf_mem[wr_ptr] <= ram_rdData;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        out_cnt <= out_cnt + CW'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (in_bounds) begin
              base_x    <= org_x;
              base_y    <= org_y;
              col       <= '0;
              row       <= '0;
              issue_cnt <= '0;
              out_cnt   <= '0;
              busy      <= 1'b1;
              state     <= READ;
            end else begin
              err <= 1'b1;
            end
          end
        end
        READ: begin
          if (ram_cs) begin
            issue_cnt <= issue_cnt + CW'(1);
            if (issue_cnt == CW'(NPIX - 1)) begin
              state <= DRAIN;
            end else if (col == ADDR_WIDTH_X'(WIN - 1)) begin
              col <= '0;
              row <= row + ADDR_WIDTH_Y'(1);
            end else begin
              col <= col + ADDR_WIDTH_X'(1);
            end
          end
        end
        DRAIN: begin
          // Finish in the cycle that empties the FIFO so done follows the
          // final handshake immediately.
          if (occ_next == 2'd0 && !inflight) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (occ_next == 2'd0 && inflight && !push) begin
            state <= DRAIN;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_window_reader.sv
// Directed bench for ram_window_reader: RAM model holds (x+y)&FF, each task
// runs one scenario and checks the collected stream inline.
module tb_ram_window_reader;

  localparam int AWX  = $clog2(300);
  localparam int AWY  = $clog2(300);
  localparam int NPIX = 400;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [AWX-1:0]       org_x = '0;
  logic [AWY-1:0]       org_y = '0;
  logic                 busy, done, err, ram_cs, ram_we;
  logic [AWX+AWY-1:0]   ram_addr;
  logic [7:0]           ram_rdData = 8'h00;
  logic [7:0]           pix_data;
  logic                 pix_valid, pix_last;
  logic                 pix_ready = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  // Per-run observations filled in by run_window.
  logic [7:0] got_q[$];
  logic       last_q[$];
  int first_valid, done_cyc, last_hs, err_seen, we_seen, rule_viol, stab_viol;
  int issued_lt30, busy0, busy_at_done;
  logic       valid_29;
  logic [7:0] data_29;

  ram_window_reader dut (
    .clk(clk), .rst(rst), .start(start), .org_x(org_x), .org_y(org_y),
    .busy(busy), .done(done), .err(err), .ram_addr(ram_addr),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_rdData(ram_rdData),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_last(pix_last)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix_at(input int x, input int y);
    return 8'((x + y) & 255);
  endfunction

  always @(posedge clk) begin
    if (ram_cs) ram_rdData <= pix_at(int'(ram_addr[AWX-1:0]), int'(ram_addr[AWX+AWY-1:AWX]));
  end

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2:       return cyc >= 30;
      default: return 1'b1;
    endcase
  endfunction

  // Index of the first pixel that deviates from the raster-order window, -1 if none.
  function automatic int seq_bad(input int ox, input int oy);
    if (got_q.size() != NPIX) return got_q.size();
    for (int i = 0; i < NPIX; i++)
      if (got_q[i] !== pix_at(ox + (i % 20), oy + (i / 20))) return i;
    return -1;
  endfunction

  function automatic int last_bad();
    for (int i = 0; i < last_q.size(); i++)
      if (last_q[i] !== (i == NPIX - 1)) return i;
    return -1;
  endfunction

  task automatic run_window(input int ox, input int oy, input int mode,
                            input int restart_at, input int stop_hs, input int max_cyc);
    int   cyc, outstanding, hs;
    logic finished, stalled;
    logic [7:0] stall_data;
    got_q.delete(); last_q.delete();
    first_valid = -1; done_cyc = -1; last_hs = -1; err_seen = 0; we_seen = 0;
    rule_viol = 0; stab_viol = 0; issued_lt30 = 0; busy0 = 0; busy_at_done = -1;
    valid_29 = 1'b0; data_29 = 8'h00;
    @(posedge clk); #1;
    start = 1'b1; org_x = AWX'(ox); org_y = AWY'(oy); pix_ready = ready_for(mode, 0);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; outstanding = 0; finished = 1'b0; stalled = 1'b0; stall_data = 8'h00;
    while (cyc < max_cyc && !finished) begin
      pix_ready = ready_for(mode, cyc);
      start = (cyc == restart_at);
      if (start) begin org_x = '0; org_y = '0; end
      #1;
      hs = (pix_valid && pix_ready) ? 1 : 0;
      if (cyc == 0) busy0 = busy;
      if (err) err_seen++;
      if (ram_we) we_seen++;
      if (ram_cs && (outstanding - hs) >= 2) rule_viol++;
      if (ram_cs && cyc < 30) issued_lt30++;
      if (cyc == 29) begin valid_29 = pix_valid; data_29 = pix_data; end
      if (pix_valid && first_valid < 0) first_valid = cyc;
      if (stalled && (!pix_valid || pix_data !== stall_data)) stab_viol++;
      stalled = pix_valid && !pix_ready;
      stall_data = pix_data;
      if (hs == 1) begin
        got_q.push_back(pix_data);
        last_q.push_back(pix_last);
        last_hs = cyc;
      end
      outstanding = outstanding + (ram_cs ? 1 : 0) - hs;
      if (done) begin done_cyc = cyc; busy_at_done = busy; finished = 1'b1; end
      if (stop_hs > 0 && got_q.size() >= stop_hs) finished = 1'b1;
      if (!finished) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    pix_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done, err, ram_cs, ram_we, pix_valid, pix_last} !== 7'b0) begin
      n_err++; $display("FAIL reset_ctrl got %b want 0000000", {busy, done, err, ram_cs, ram_we, pix_valid, pix_last});
    end
    n_vec++;
    if (ram_addr !== '0 || pix_data !== 8'h00) begin
      n_err++; $display("FAIL reset_data got addr=%0h data=%0h want 0/0", ram_addr, pix_data);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    run_window(10, 5, 0, -1, 0, 2000);
    n_vec++;
    if (done_cyc < 0) begin n_err++; $display("FAIL basic_timeout got no done want done"); end
    n_vec++;
    if (first_valid !== 2) begin n_err++; $display("FAIL basic_latency got %0d want 2", first_valid); end
    n_vec++;
    if (busy0 !== 1) begin n_err++; $display("FAIL basic_busy got %0d want 1", busy0); end
    n_vec++;
    if (seq_bad(10, 5) !== -1) begin n_err++; $display("FAIL basic_seq got bad index %0d (size %0d) want -1", seq_bad(10, 5), got_q.size()); end
    n_vec++;
    if (last_bad() !== -1) begin n_err++; $display("FAIL basic_last got bad index %0d want -1", last_bad()); end
    n_vec++;
    if (last_hs - first_valid !== NPIX - 1) begin n_err++; $display("FAIL basic_throughput got %0d want %0d", last_hs - first_valid, NPIX - 1); end
    n_vec++;
    if (done_cyc !== last_hs + 1) begin n_err++; $display("FAIL basic_done got %0d want %0d", done_cyc, last_hs + 1); end
    n_vec++;
    if (busy_at_done !== 0) begin n_err++; $display("FAIL basic_busy_done got %0d want 0", busy_at_done); end
    n_vec++;
    if (we_seen !== 0 || err_seen !== 0) begin n_err++; $display("FAIL basic_we_err got we=%0d err=%0d want 0/0", we_seen, err_seen); end
  endtask

  task automatic test_backpressure();
    run_window(10, 5, 1, -1, 0, 3000);
    n_vec++;
    if (seq_bad(10, 5) !== -1) begin n_err++; $display("FAIL bp_seq got bad index %0d (size %0d) want -1", seq_bad(10, 5), got_q.size()); end
    n_vec++;
    if (last_bad() !== -1) begin n_err++; $display("FAIL bp_last got bad index %0d want -1", last_bad()); end
    n_vec++;
    if (stab_viol !== 0) begin n_err++; $display("FAIL bp_stable got %0d want 0", stab_viol); end
    n_vec++;
    if (rule_viol !== 0) begin n_err++; $display("FAIL bp_issue_rule got %0d want 0", rule_viol); end
    n_vec++;
    if (done_cyc < 0) begin n_err++; $display("FAIL bp_timeout got no done want done"); end
  endtask

  task automatic test_edge_window();
    run_window(280, 0, 0, -1, 0, 2000);
    n_vec++;
    if (seq_bad(280, 0) !== -1) begin n_err++; $display("FAIL edge_seq got bad index %0d (size %0d) want -1", seq_bad(280, 0), got_q.size()); end
    n_vec++;
    if (got_q.size() != NPIX || got_q[NPIX-1] !== 8'd62) begin
      n_err++; $display("FAIL edge_lastpix got %0h want 3e", (got_q.size() > 0) ? got_q[got_q.size()-1] : 8'hxx);
    end
    n_vec++;
    if (err_seen !== 0) begin n_err++; $display("FAIL edge_err got %0d want 0", err_seen); end
  endtask

  task automatic test_reject();
    int cs_seen, busy_seen, err_late;
    @(posedge clk); #1;
    start = 1'b1; org_x = AWX'(281); org_y = '0;
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++;
    if (err !== 1'b1) begin n_err++; $display("FAIL reject_err got %b want 1", err); end
    cs_seen = 0; busy_seen = 0; err_late = 0;
    for (int i = 0; i < 6; i++) begin
      if (ram_cs) cs_seen++;
      if (busy) busy_seen++;
      if (i > 0 && err) err_late++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (cs_seen !== 0 || busy_seen !== 0) begin n_err++; $display("FAIL reject_idle got cs=%0d busy=%0d want 0/0", cs_seen, busy_seen); end
    n_vec++;
    if (err_late !== 0) begin n_err++; $display("FAIL reject_pulse got %0d extra err cycles want 0", err_late); end
  endtask

  task automatic test_restart();
    run_window(10, 5, 0, 50, 0, 2000);
    n_vec++;
    if (seq_bad(10, 5) !== -1) begin n_err++; $display("FAIL restart_seq got bad index %0d (size %0d) want -1", seq_bad(10, 5), got_q.size()); end
    n_vec++;
    if (err_seen !== 0) begin n_err++; $display("FAIL restart_err got %0d want 0", err_seen); end
  endtask

  task automatic test_reset_mid();
    run_window(10, 5, 0, -1, 137, 2000);
    n_vec++;
    if (got_q.size() !== 137) begin n_err++; $display("FAIL rstmid_count got %0d want 137", got_q.size()); end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({busy, done, err, ram_cs, pix_valid, pix_last} !== 6'b0 || ram_addr !== '0 || pix_data !== 8'h00) begin
      n_err++; $display("FAIL rstmid_async got ctrl=%b addr=%0h data=%0h want 0", {busy, done, err, ram_cs, pix_valid, pix_last}, ram_addr, pix_data);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    run_window(0, 0, 0, -1, 0, 2000);
    n_vec++;
    if (seq_bad(0, 0) !== -1) begin n_err++; $display("FAIL rstmid_seq got bad index %0d (size %0d) want -1", seq_bad(0, 0), got_q.size()); end
    n_vec++;
    if (last_bad() !== -1 || done_cyc !== last_hs + 1) begin n_err++; $display("FAIL rstmid_end got last_bad=%0d done=%0d want -1/%0d", last_bad(), done_cyc, last_hs + 1); end
  endtask

  task automatic test_stall();
    run_window(10, 5, 2, -1, 0, 2000);
    n_vec++;
    if (issued_lt30 !== 2) begin n_err++; $display("FAIL stall_issues got %0d want 2", issued_lt30); end
    n_vec++;
    if (valid_29 !== 1'b1 || data_29 !== 8'd15) begin n_err++; $display("FAIL stall_head got v=%b d=%0d want 1/15", valid_29, data_29); end
    n_vec++;
    if (seq_bad(10, 5) !== -1) begin n_err++; $display("FAIL stall_seq got bad index %0d (size %0d) want -1", seq_bad(10, 5), got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_edge_window();
    test_reject();
    test_restart();
    test_reset_mid();
    test_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_window_reader.md
Name: ram_window_reader

Overview:
- Downstream consumer of the ipgu single-port image RAM.
- Given a window origin, it issues a raster-order read sequence to the RAM for a WIN x WIN window and streams the pixels out over a valid/ready interface.
- Its consumer is the window-processing stage.
- It hides the RAM's 1-cycle read latency and absorbs output backpressure with a 2-entry buffer.

Parameters:
- DEPTH_X, 300, image width in pixels (RAM X depth)
- DEPTH_Y, 300, image height in pixels (RAM Y depth)
- ADDR_WIDTH_X, $clog2(DEPTH_X), RAM X address width
- ADDR_WIDTH_Y, $clog2(DEPTH_Y), RAM Y address width
- DATA_WIDTH, 8, pixel width
- WIN, 20, window edge length in pixels

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  asynchronous active-high reset
- start  in  1  request a window read; sampled in IDLE only
- org_x  in  ADDR_WIDTH_X  window left column, sampled with start
- org_y  in  ADDR_WIDTH_Y  window top row, sampled with start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse, window fully delivered
- err  out  1  one-cycle pulse, start rejected (window out of bounds)
- ram_addr  out  ADDR_WIDTH_X+ADDR_WIDTH_Y  {y,x} read address to RAM
- ram_cs  out  1  RAM chip select
- ram_we  out  1  constant 0 (read-only master)
- ram_rdData  in  DATA_WIDTH  RAM read data, valid the cycle after ram_cs
- pix_data  out  DATA_WIDTH  output pixel
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  consumer accepts when pix_valid & pix_ready
- pix_last  out  1  qualifies final (WIN*WIN-th) pixel of window

Behaviour:
- Reset (async, any state):
  - state=IDLE; counters and buffer cleared.
  - busy, done, err, ram_cs, pix_valid, pix_last = 0; ram_addr = 0; pix_data = 0.
- States:
  - IDLE -> READ on start with org_x+WIN <= DEPTH_X and org_y+WIN <= DEPTH_Y. Origin latched; busy=1 from the next cycle.
  - IDLE stays IDLE on start with an out-of-bounds window; err pulses 1 cycle the following cycle; no RAM access.
  - READ: issues reads x-inner, y-outer: (org_y+r, org_x+c), c=0..WIN-1, r=0..WIN-1. After the WIN*WIN-th issue -> DRAIN.
  - DRAIN: no reads; waits until the buffer is empty and no read is in flight -> DONE.
  - DONE: done=1 for one cycle, busy=0 that same cycle -> IDLE.
- Bounds compare uses ADDR_WIDTH+1-bit arithmetic, so no wrap.
- Issue rule: ram_cs=1 in a cycle only if (buffer occupancy + reads in flight - (pix_valid&pix_ready)) < 2. Guarantees no returned data is ever dropped. ram_we always 0.
- RAM data is captured into the buffer the cycle after each ram_cs=1.
- Buffer: 2-entry FIFO; pix_data/pix_valid driven from its head.
  - Simultaneous push and pop: occupancy unchanged, order preserved.
- Latency: with pix_ready held 1, the first pix_valid appears 2 cycles after start is sampled.
- Throughput: 1 pixel/cycle sustained (400 pixels in 400 consecutive cycles for WIN=20).
- pix_valid holds while !pix_ready; pix_data stable until accepted (AXI-stream rules).
- pix_last=1 only with the final pixel's pix_valid.
- start while busy is ignored (no latch, no err).
- Pixel count: WIN*WIN, counter width $clog2(WIN*WIN+1).

Test Plan:
- Defaults; RAM preloaded with mem[y][x]=(x+y)&8'hFF. start, org=(10,5), pix_ready=1 -> 400 pixels with values (10+c+5+r)&FF in raster order; first pix_valid 2 cycles after start; pix_last on pixel 400; done one cycle after the last handshake.
- Same window, pix_ready toggling 1,0,0,1 repeatedly -> identical 400-pixel sequence with no loss or duplication; pix_data stable while stalled; ram_cs never issues with 2 entries buffered.
- org=(280,0) (280+20=300, in bounds) -> accepted, last pixel from x=299, y=19. org=(281,0) -> err pulse, ram_cs never asserted, busy stays 0.
- start pulsed again at cycle 50 of an active window with org=(0,0) -> ignored; current window completes unchanged; no err.
- rst asserted mid-READ (after 137 pixels) -> all outputs 0 immediately (async); after release, start org=(0,0) -> clean full 400-pixel window.
- pix_ready held 0 for 30 cycles after start -> exactly 2 reads issued; pix_valid=1 holding the first pixel; on release the stream resumes in order.
